// File: rtl/sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_capture
// Brief    : Receives a multiplexed seven-segment bus, recovers the four
//            displayed codes and publishes them once stable over frames.
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int MATCH_FRAMES   = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  segments,
    input  logic [3:0]  anodes,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        bad_pattern,
    output logic        display_off
);

    localparam int                   c_CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]   c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam int                   c_MATCH_W     = $clog2(MATCH_FRAMES + 1);
    localparam logic [c_MATCH_W-1:0] c_MATCH_MAX   = c_MATCH_W'(MATCH_FRAMES);
    localparam int                   c_TO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0]    c_TO_MAX      = c_TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    function automatic logic [3:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: return 4'h0;
            7'b1111001: return 4'h1;
            7'b0100100: return 4'h2;
            7'b0110000: return 4'h3;
            7'b0011001: return 4'h4;
            7'b0010010: return 4'h5;
            7'b0000010: return 4'h6;
            7'b1111000: return 4'h7;
            7'b0000000: return 4'h8;
            7'b0010000: return 4'h9;
            7'b1111111: return 4'hA;
            7'b0111111: return 4'hB;
            default:    return 4'hF;
        endcase
    endfunction

    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_settle;
    logic [c_CNT_W-1:0]   w_settle_nxt;
    logic                 w_change;
    logic                 w_capture;
    logic                 w_sel_valid;
    logic [1:0]           w_sel_idx;
    logic [3:0]           w_code;
    logic [15:0]          r_buf;
    logic [15:0]          r_prev;
    logic [15:0]          r_digits;
    logic [3:0]           r_mask;
    logic [c_MATCH_W-1:0] r_match;
    logic [c_MATCH_W-1:0] w_match_nxt;
    logic                 w_full;
    logic                 w_publish;
    logic [c_TO_W-1:0]    r_to;
    logic                 r_frame_valid;
    logic                 r_bad;
    logic                 r_off;
    logic                 r_published;

    // The raw bus is compared with its registered copy so the settle count
    // restarts in the same edge that loads the new value.
    assign w_change = ({anodes, segments} != {r_an, r_seg});
    assign w_code   = f_decode(r_seg);
    assign w_full   = &r_mask;

    always_comb begin
        w_sel_valid = 1'b1;
        w_sel_idx   = 2'd0;
        case (r_an)
            4'b1110: w_sel_idx = 2'd0;
            4'b1101: w_sel_idx = 2'd1;
            4'b1011: w_sel_idx = 2'd2;
            4'b0111: w_sel_idx = 2'd3;
            default: w_sel_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_capture    = 1'b0;
        if (w_change) begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = '0;
        end else if (r_state == ST_SETTLE) begin
            if (r_settle == c_SETTLE_LAST) begin
                w_capture   = w_sel_valid;
                w_state_nxt = w_sel_valid ? ST_HELD : ST_WAIT;
            end else begin
                w_settle_nxt = r_settle + 1'b1;
            end
        end
    end

    always_comb begin
        w_match_nxt = r_match;
        if (r_buf != r_prev) begin
            w_match_nxt = c_MATCH_W'(1);
        end else if (r_match != c_MATCH_MAX) begin
            w_match_nxt = r_match + 1'b1;
        end
    end

    assign w_publish = w_full && (w_match_nxt == c_MATCH_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an          <= 4'hF;
            r_seg         <= 7'h7F;
            r_state       <= ST_WAIT;
            r_settle      <= '0;
            r_buf         <= '0;
            r_prev        <= '0;
            r_mask        <= '0;
            r_match       <= '0;
            r_to          <= '0;
            r_digits      <= 16'hAAAA;
            r_frame_valid <= 1'b0;
            r_bad         <= 1'b0;
            r_off         <= 1'b0;
            r_published   <= 1'b0;
        end else begin
            r_an          <= anodes;
            r_seg         <= segments;
            r_state       <= w_state_nxt;
            r_settle      <= w_settle_nxt;
            r_frame_valid <= 1'b0;

            if (w_full) begin
                r_prev  <= r_buf;
                r_match <= w_match_nxt;
                r_mask  <= '0;
                if (w_publish) begin
                    r_digits    <= r_buf;
                    r_published <= 1'b1;
                    if (!r_published || (r_buf != r_digits)) begin
                        r_frame_valid <= 1'b1;
                    end
                end
            end

            // Later assignments win, so a capture re-sets its mask bit even
            // in the cycle a completed frame clears the mask.
            if (w_capture) begin
                r_buf[{w_sel_idx, 2'b00} +: 4] <= w_code;
                r_mask[w_sel_idx]              <= 1'b1;
                r_to                           <= '0;
                r_off                          <= 1'b0;
                if (w_code == 4'hF) begin
                    r_bad <= 1'b1;
                end
            end else if (r_to != c_TO_MAX) begin
                r_to <= r_to + 1'b1;
                if (r_to == c_TO_MAX - 1'b1) begin
                    r_off   <= 1'b1;
                    r_mask  <= '0;
                    r_match <= '0;
                end
            end
        end
    end

    assign digits      = r_digits;
    assign frame_valid = r_frame_valid;
    assign bad_pattern = r_bad;
    assign display_off = r_off;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_capture
// Brief    : Self-checking bench for sevenseg_capture with a run-length
//            reference model, a decode vector table and directed sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_capture;

    localparam int SETTLE  = 4;
    localparam int MATCH   = 2;
    localparam int TIMEOUT = 64;

    localparam logic [6:0] P0  = 7'b1000000;
    localparam logic [6:0] P1  = 7'b1111001;
    localparam logic [6:0] P2  = 7'b0100100;
    localparam logic [6:0] P3  = 7'b0110000;
    localparam logic [6:0] P5  = 7'b0010010;
    localparam logic [6:0] P7  = 7'b1111000;
    localparam logic [6:0] P8  = 7'b0000000;
    localparam logic [6:0] PB  = 7'b1111111;
    localparam logic [6:0] PM  = 7'b0111111;
    localparam logic [6:0] PX  = 7'b1010101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an  = 4'hF;
    logic [15:0] digits;
    logic        frame_valid;
    logic        bad_pattern;
    logic        display_off;

    sevenseg_capture #(
        .SETTLE_CYCLES (SETTLE),
        .MATCH_FRAMES  (MATCH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .segments   (seg),
        .anodes     (an),
        .digits     (digits),
        .frame_valid(frame_valid),
        .bad_pattern(bad_pattern),
        .display_off(display_off)
    );

    always #5 clk = ~clk;

    // Table position doubles as the code: 0-9 digits, 10 blank, 11 minus.
    logic [6:0] pat_tab [12] = '{P0, P1, P2, P3, 7'b0011001, P5, 7'b0000010,
                                 P7, P8, 7'b0010000, PB, PM};

    typedef struct {
        logic [6:0] seg;
        logic [3:0] exp_code;
        logic       exp_bad;
    } vec_t;
    vec_t vecs [14];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int pulses   = 0;
    int last_fv_cyc = 0;

    // Reference model state
    logic [15:0] m_buf, m_prev, m_digits;
    logic [3:0]  m_mask;
    logic [10:0] m_prev_in;
    int          m_run, m_match, m_to;
    logic        m_fv, m_bad, m_off, m_pub;

    function automatic logic [3:0] m_decode(input logic [6:0] p);
        for (int i = 0; i < 12; i++) if (pat_tab[i] == p) return 4'(i);
        return 4'hF;
    endfunction

    // A captured dwell is one whose bus value has been present for
    // SETTLE+1 consecutive edges with exactly one anode low.
    task automatic model_step();
        int idx;
        logic [3:0] code;
        if (rst) begin
            m_buf = '0; m_prev = '0; m_digits = 16'hAAAA; m_mask = '0;
            m_prev_in = 11'h7FF; m_run = 100; m_match = 0; m_to = 0;
            m_fv = 0; m_bad = 0; m_off = 0; m_pub = 0;
        end else begin
            if ({an, seg} == m_prev_in) m_run = m_run + 1;
            else m_run = 1;
            m_prev_in = {an, seg};
            m_fv = 0;
            if (m_mask == 4'hF) begin
                if (m_buf == m_prev) m_match = (m_match >= MATCH) ? MATCH : m_match + 1;
                else m_match = 1;
                m_prev = m_buf;
                m_mask = '0;
                if (m_match == MATCH) begin
                    if (!m_pub || m_buf != m_digits) m_fv = 1;
                    m_digits = m_buf;
                    m_pub = 1;
                end
            end
            if (m_run == SETTLE + 1 && $countones(~an) == 1) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
                code = m_decode(seg);
                m_buf[idx*4 +: 4] = code;
                m_mask[idx] = 1'b1;
                m_to = 0;
                m_off = 0;
                if (code == 4'hF) m_bad = 1;
            end else if (m_to < TIMEOUT) begin
                m_to = m_to + 1;
                if (m_to == TIMEOUT) begin
                    m_off = 1; m_mask = '0; m_match = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        if (frame_valid) begin
            pulses++;
            last_fv_cyc = cyc;
        end
        n_checks++;
        if ({digits, frame_valid, bad_pattern, display_off} !== {m_digits, m_fv, m_bad, m_off}) begin
            n_err++;
            $display("FAIL model cyc=%0d digits=%h/%h fv=%b/%b bad=%b/%b off=%b/%b (got/exp)",
                     cyc, digits, m_digits, frame_valid, m_fv, bad_pattern, m_bad, display_off, m_off);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] p, input int n);
        an  = a;
        seg = p;
        repeat (n) tick();
    endtask

    task automatic digit(input int idx, input logic [6:0] p);
        drive(4'hF & ~(4'b0001 << idx), p, 16);
        drive(4'hF, 7'h7F, 2);
    endtask

    task automatic frame(input logic [6:0] p3, input logic [6:0] p2,
                         input logic [6:0] p1, input logic [6:0] p0);
        digit(3, p3); digit(2, p2); digit(1, p1); digit(0, p0);
    endtask

    task automatic do_reset();
        an = 4'hF; seg = 7'h7F;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = 0;
    endtask

    logic [6:0] pool [3][4];

    initial begin
        int c0, fsel, g;
        logic [3:0] a;

        vecs[0]  = '{P0,          4'h0, 1'b0};
        vecs[1]  = '{P1,          4'h1, 1'b0};
        vecs[2]  = '{P2,          4'h2, 1'b0};
        vecs[3]  = '{P3,          4'h3, 1'b0};
        vecs[4]  = '{7'b0011001,  4'h4, 1'b0};
        vecs[5]  = '{P5,          4'h5, 1'b0};
        vecs[6]  = '{7'b0000010,  4'h6, 1'b0};
        vecs[7]  = '{P7,          4'h7, 1'b0};
        vecs[8]  = '{P8,          4'h8, 1'b0};
        vecs[9]  = '{7'b0010000,  4'h9, 1'b0};
        vecs[10] = '{PB,          4'hA, 1'b0};
        vecs[11] = '{PM,          4'hB, 1'b0};
        vecs[12] = '{PX,          4'hF, 1'b1};
        vecs[13] = '{7'b1111110,  4'hF, 1'b1};

        do_reset();
        check("reset_digits", 32'(digits), 32'(16'hAAAA));
        check("reset_flags", 32'({frame_valid, bad_pattern, display_off}), 0);

        for (int i = 0; i < 14; i++) begin
            do_reset();
            repeat (2) frame(PB, PB, PB, vecs[i].seg);
            check($sformatf("vec%0d_digits", i), 32'(digits), 32'({12'hAAA, vecs[i].exp_code}));
            check($sformatf("vec%0d_bad", i), 32'(bad_pattern), 32'(vecs[i].exp_bad));
            check($sformatf("vec%0d_pulses", i), pulses, 1);
        end

        // "  50": publish after two frames, latency and no repeat pulses
        do_reset();
        frame(PB, PB, P5, P0);
        digit(3, PB); digit(2, PB); digit(1, P5);
        c0 = cyc;
        digit(0, P0);
        check("t1_digits", 32'(digits), 32'(16'hAA50));
        check("t1_pulses", pulses, 1);
        check("t1_latency", last_fv_cyc - c0, 6);
        repeat (3) frame(PB, PB, P5, P0);
        check("t1_no_repulse", pulses, 1);

        // "  50" then "-100"
        do_reset();
        repeat (2) frame(PB, PB, P5, P0);
        repeat (2) frame(PM, P1, P0, P0);
        check("t2_digits", 32'(digits), 32'(16'hB100));
        check("t2_pulses", pulses, 2);

        // Alternating frames never publish
        do_reset();
        repeat (3) begin
            frame(P0, P0, P1, P2);
            frame(P0, P0, P1, P3);
        end
        check("t3_pulses", pulses, 0);
        check("t3_digits", 32'(digits), 32'(16'hAAAA));

        // Short dwell and two-anode dwell do not capture; a 5-cycle dwell does
        do_reset();
        repeat (2) begin
            digit(3, P1); digit(2, P2); digit(1, P3);
            drive(4'b1110, P0, 3); drive(4'hF, 7'h7F, 2);
            drive(4'b0011, P8, 16); drive(4'hF, 7'h7F, 2);
        end
        check("t4_pulses", pulses, 0);
        check("t4_digits", 32'(digits), 32'(16'hAAAA));
        repeat (2) begin
            digit(3, P1); digit(2, P2); digit(1, P3);
            drive(4'b1110, P5, 5); drive(4'hF, 7'h7F, 2);
        end
        check("t4_min_dwell_pulses", pulses, 1);
        check("t4_min_dwell_digits", 32'(digits), 32'(16'h1235));

        // Undecodable pattern on digit 1, cleared by reset
        do_reset();
        repeat (2) frame(P1, P2, PX, P3);
        check("t5_digits", 32'(digits), 32'(16'h12F3));
        check("t5_bad", 32'(bad_pattern), 1);
        do_reset();
        check("t5_bad_after_rst", 32'(bad_pattern), 0);
        check("t5_digits_after_rst", 32'(digits), 32'(16'hAAAA));

        // Timeout clears the match history; reset mid-frame
        do_reset();
        repeat (2) frame(PB, PB, P5, P0);
        frame(PB, PB, P7, P7);
        drive(4'hF, 7'h7F, 70);
        check("t6_off", 32'(display_off), 1);
        check("t6_held", 32'(digits), 32'(16'hAA50));
        digit(3, PB);
        check("t6_off_cleared", 32'(display_off), 0);
        digit(2, PB); digit(1, P7); digit(0, P7);
        check("t6_one_fresh_frame", 32'(digits), 32'(16'hAA50));
        check("t6_one_fresh_pulses", pulses, 1);
        frame(PB, PB, P7, P7);
        check("t6_two_fresh_frames", 32'(digits), 32'(16'hAA77));
        check("t6_two_fresh_pulses", pulses, 2);
        digit(3, PB);
        drive(4'b1101, P7, 8);
        rst = 1'b1;
        tick();
        check("t6_rst_digits", 32'(digits), 32'(16'hAAAA));
        check("t6_rst_flags", 32'({frame_valid, bad_pattern, display_off}), 0);
        rst = 1'b0;
        pulses = 0;
        drive(4'b1101, P7, 8); drive(4'hF, 7'h7F, 2);
        digit(0, P7);
        repeat (2) frame(PB, PB, P7, P7);
        check("t6_after_rst_digits", 32'(digits), 32'(16'hAA77));
        check("t6_after_rst_pulses", pulses, 1);

        // Randomized scanning against the model
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int d = 0; d < 4; d++)
                pool[p][d] = ($urandom_range(0, 29) == 0) ? 7'($urandom) : pat_tab[$urandom_range(0, 11)];
        fsel = 0;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 1) == 0) fsel = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) drive(4'hF, 7'h7F, $urandom_range(60, 80));
            for (int d = 3; d >= 0; d--) begin
                a = 4'hF & ~(4'b0001 << d);
                if ($urandom_range(0, 19) == 0) a = 4'($urandom);
                drive(a, pool[fsel][d], $urandom_range(3, 20));
                g = $urandom_range(0, 3);
                if (g != 0) drive(4'hF, 7'h7F, g);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Listens to the multiplexed seven-segment bus (segments/anodes) that the calculator top level drives.
- Recovers the four displayed characters as codes.
- Reports a value only after it has been shown unchanged for several complete scan frames.
- Sits beside the display driver as an on-chip self-check and as a bench monitor; it is the receiving end of the display interface.

Parameters:
- SETTLE_CYCLES, 4: consecutive identical samples required before a digit is captured.
- MATCH_FRAMES, 2: consecutive identical complete frames required before publishing.
- TIMEOUT_CYCLES, 1048576: cycles without any capture before display_off is asserted.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- segments  input  7  active-low segment lines; bit6..bit0 = g,f,e,d,c,b,a
- anodes  input  4  active-low digit enables; anodes[0] = rightmost digit
- digits  output  16  published characters, 4 bits per digit; [3:0] = rightmost
- frame_valid  output  1  one-cycle pulse when digits is loaded with a new value
- bad_pattern  output  1  sticky; set when an undecodable segment pattern is captured
- display_off  output  1  high while no capture has occurred for TIMEOUT_CYCLES

Behaviour:
- Decision: one clock, reset is synchronous and active-high, ports named clk and rst.
- Inputs are registered once. All timing below counts from the registered copy.
- Reset values:
  - digits = 16'hAAAA (all blank)
  - frame_valid = 0, bad_pattern = 0, display_off = 0
  - capture mask, frame buffer, match counter, settle counter and timeout counter all cleared
- Decode table (active-low gfedcba), pattern -> code:
  - 0: 1000000 -> 0
  - 1: 1111001 -> 1
  - 2: 0100100 -> 2
  - 3: 0110000 -> 3
  - 4: 0011001 -> 4
  - 5: 0010010 -> 5
  - 6: 0000010 -> 6
  - 7: 1111000 -> 7
  - 8: 0000000 -> 8
  - 9: 0010000 -> 9
  - blank 1111111 -> A
  - minus 0111111 -> B
  - anything else -> F, and bad_pattern is set
- Per-dwell state machine with states WAIT, SETTLE and HELD:
  - A change in {anodes, segments} returns the machine to SETTLE and sets the settle counter to 0. This applies from any state.
  - SETTLE counts identical samples. When the count reaches SETTLE_CYCLES-1:
    - If anodes has exactly one bit low, write the decoded code into the frame buffer for that index, set its mask bit, and go to HELD.
    - Otherwise go to WAIT. WAIT covers blanking gaps: all anodes high, or more than one anode low.
  - HELD and WAIT perform no further capture until the input changes.
- A digit index captured again before the mask is full overwrites its buffer entry.
- Frame completion, in the cycle after the mask becomes 4'b1111:
  - If the buffer equals the previous frame, the match counter increments and saturates at MATCH_FRAMES. Otherwise the match counter is set to 1.
  - The previous frame is set to the buffer, and the mask is cleared.
- Publishing: when the match counter equals MATCH_FRAMES at frame completion:
  - digits is loaded from the buffer.
  - frame_valid pulses for exactly one cycle, only if the buffer differs from the current digits or nothing has been published since reset.
  - Further identical frames do not pulse again.
- Timeout:
  - The timeout counter clears on every capture and saturates at TIMEOUT_CYCLES.
  - At saturation: display_off = 1, mask is cleared, match counter is cleared, and digits holds its last value.
  - The first capture afterwards clears display_off in the same cycle the mask bit is set.
- Frames containing code F are processed and published like any other frame.
- bad_pattern clears only on rst.
- rst asserted mid-frame returns all state to reset values on the next edge. Partial frames are discarded.
- Latency: the last digit of the qualifying frame becomes stable, then frame_valid appears SETTLE_CYCLES+2 cycles later (1 input register, SETTLE_CYCLES-1 count, 1 capture, 1 completion).

Test Plan:
Bench parameters: SETTLE_CYCLES=4, MATCH_FRAMES=2, TIMEOUT_CYCLES=64; dwell of 16 cycles per digit plus a 2-cycle all-high gap.
1. Scan "  50" (anodes[3..0] = blank, blank, 0010010, 1000000) for 2 frames -> digits = 16'hAA50; one frame_valid pulse, 6 cycles after the second frame's last digit is stable; no pulse on frames 3 to 5.
2. Scan "  50" for 2 frames, then "-100" (0111111, 1111001, 1000000, 1000000) for 2 frames -> digits = 16'hB100; exactly two pulses in total.
3. Alternate the frames "0012" / "0013" every frame -> no frame_valid; digits stays 16'hAAAA.
4. Hold a digit for only 3 cycles, or drive anodes = 4'b0011 -> no capture; mask unchanged; no pulse.
5. Drive segments = 7'b1010101 on digit 1 for 2 frames -> bad_pattern = 1 and digit 1 = F; after rst, bad_pattern = 0 and digits = 16'hAAAA.
6. Stop scanning (anodes = 4'hF) for 64 cycles -> display_off = 1, digits held; resume scanning -> display_off = 0 at the first capture, and a publish requires 2 fresh frames. Also assert rst for 1 cycle mid-frame -> all outputs at reset values on the next cycle.
